// File: rtl/arb_mux.sv
// Arbitrating N-channel mux with valid/ready handshakes and a one-entry output register.
// Define ARB_MUX_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module arb_mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_channel
);

  // Handshake: a word moves on a rising edge where valid && ready are both high;
  // in_valid never waits on in_ready, and in_ready is only ever high on the granted channel.

  logic                r_valid;
  logic [WIDTH-1:0]    r_data;
  logic [SEL_W-1:0]    r_chan;

  logic                w_load;
  logic                w_any;
  logic                w_in_xfer;
  logic [CHANNELS-1:0] w_grant;
  logic [SEL_W-1:0]    w_win_idx;
  logic [WIDTH-1:0]    w_win_data;

`ifdef ARB_MUX_ROUND_ROBIN_EN
  logic [SEL_W-1:0]    r_ptr;
  logic [SEL_W:0]      w_idx;
  logic [SEL_W-1:0]    w_pos;

  // Search upward from r_ptr with wrap at CHANNELS, so unused power-of-two slots never appear.
  always_comb begin
    w_grant   = '0;
    w_win_idx = '0;
    w_any     = 1'b0;
    w_idx     = '0;
    w_pos     = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_idx = {1'b0, r_ptr} + (SEL_W+1)'(k);
      if (w_idx >= (SEL_W+1)'(CHANNELS)) begin
        w_idx = w_idx - (SEL_W+1)'(CHANNELS);
      end
      w_pos = w_idx[SEL_W-1:0];
      if (!w_any && in_valid[w_pos]) begin
        w_any          = 1'b1;
        w_grant[w_pos] = 1'b1;
        w_win_idx      = w_pos;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_in_xfer) begin
      r_ptr <= (w_win_idx == SEL_W'(CHANNELS-1)) ? '0 : w_win_idx + 1'b1;
    end
  end
`else
  always_comb begin
    w_grant   = '0;
    w_win_idx = '0;
    w_any     = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!w_any && in_valid[k]) begin
        w_any      = 1'b1;
        w_grant[k] = 1'b1;
        w_win_idx  = SEL_W'(k);
      end
    end
  end
`endif

  // Gating with reset keeps in_ready low while the register is held clear.
  assign w_load    = !reset && (!r_valid || out_ready);
  assign in_ready  = w_grant & {CHANNELS{w_load}};
  assign w_in_xfer = w_any && w_load;

  always_comb begin
    w_win_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_grant[k]) begin
        w_win_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
    end else if (w_in_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_win_data;
      r_chan  <= w_win_idx;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_data    = r_data;
  assign out_channel = r_chan;

endmodule
